// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the gpio_port register block.
//   - register offsets (word index = addr[4:2])
//   - register-index width
//   - default byte base address of the register window
//   - byte_mask(): expands the 4-bit byte write enable to a 32-bit bit mask
package gpio_pkg;

    localparam int unsigned GPIO_REG_IDX_W = 3;

    localparam logic [GPIO_REG_IDX_W-1:0] GPIO_OUT     = 3'd0;
    localparam logic [GPIO_REG_IDX_W-1:0] GPIO_DIR     = 3'd1;
    localparam logic [GPIO_REG_IDX_W-1:0] GPIO_IN      = 3'd2;
    localparam logic [GPIO_REG_IDX_W-1:0] GPIO_SET     = 3'd3;
    localparam logic [GPIO_REG_IDX_W-1:0] GPIO_CLR     = 3'd4;
    localparam logic [GPIO_REG_IDX_W-1:0] GPIO_RISE_EN = 3'd5;
    localparam logic [GPIO_REG_IDX_W-1:0] GPIO_FALL_EN = 3'd6;
    localparam logic [GPIO_REG_IDX_W-1:0] GPIO_PENDING = 3'd7;

    localparam logic [31:0] GPIO_BASE_ADDR = 32'h0001_0000;

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: input conditioning for a vector of asynchronous pins.
//   SYNC_STAGES-deep synchroniser, optional debounce filter, then
//   rise/fall detection against the previous conditioned value.
// Optional feature: define GPIO_DEBOUNCE_EN to insert a 3-sample debounce
//   filter clocked by a shared prescaler tick every DEBOUNCE_DIV cycles.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   io_in       raw pin inputs
//   rise_en     per-pin rising-edge enable
//   fall_en     per-pin falling-edge enable
//   level       conditioned pin level (synchronised, filtered if enabled)
//   rise, fall  enabled edge events, valid for one cycle
module gpio_sync_edge #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_DIV = 1200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] io_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

    logic [CNT_W-1:0] div_cnt;
    logic             tick;
    logic [WIDTH-1:0] s0, s1, s2;
    logic [WIDTH-1:0] filt;

    assign tick = (div_cnt == CNT_W'(DEBOUNCE_DIV - 1));

    // filt goes high where all samples are 1, low where all are 0,
    // and otherwise keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            s0      <= '0;
            s1      <= '0;
            s2      <= '0;
            filt    <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
            if (tick) begin
                s2 <= s1;
                s1 <= s0;
                s0 <= sync;
            end
            filt <= (filt | (s0 & s1 & s2)) & (s0 | s1 | s2);
        end
    end

    assign level = filt;
`else
    assign level = sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '0;
        else        prev <= level;
    end

    assign rise = level & ~prev & rise_en;
    assign fall = ~level & prev & fall_en;

endmodule

// File: rtl/gpio_port.sv
// gpio_port: memory-mapped bidirectional GPIO block for one bus_hub slot.
//   Registers (word index addr[4:2]): OUT, DIR, IN, SET, CLR, RISE_EN,
//   FALL_EN, PENDING (rw1c). Byte writes gated by wmask. Bits at and above
//   WIDTH read 0 and ignore writes.
// Optional feature: GPIO_DEBOUNCE_EN (input debounce, see gpio_sync_edge).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   addr, wdata, wmask bus address, write data, byte enables
//   wen, ren           write / read strobes
//   rdata, ready       registered read data, one-cycle completion pulse
//   active             combinational window decode
//   io_in/io_out/io_oe pin input, output register, output enable
//   irq                registered OR of enabled pending events
module gpio_port
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter logic [31:0] BASE_ADDR    = GPIO_BASE_ADDR,
    parameter int unsigned ADDR_BITS    = 5,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_DIV = 1200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wmask,
    input  logic             wen,
    input  logic             ren,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             active,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] io_oe,
    output logic             irq
);

    logic [GPIO_REG_IDX_W-1:0] idx;
    logic                      acc;
    logic                      wr;
    logic [31:0]               bm32;
    logic [WIDTH-1:0]          bm;
    logic [WIDTH-1:0]          wset;
    logic [WIDTH-1:0]          w1c;
    logic [31:0]               rd_val;

    logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, pending_q;
    logic [WIDTH-1:0] level, rise, fall;

    assign active = (addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    assign idx    = addr[2 +: GPIO_REG_IDX_W];
    assign acc    = (wen | ren) & active;
    assign wr     = acc & wen;
    assign bm32   = byte_mask(wmask);
    assign bm     = bm32[WIDTH-1:0];
    assign wset   = wdata[WIDTH-1:0] & bm;
    assign w1c    = (wr && idx == GPIO_PENDING) ? wset : '0;

    logic unused_ok;
    assign unused_ok = ^{addr, wdata, bm32};

    gpio_sync_edge #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_DIV (DEBOUNCE_DIV)
    ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_in   (io_in),
        .rise_en (rise_en_q),
        .fall_en (fall_en_q),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    always_comb begin
        rd_val = '0;
        case (idx)
            GPIO_OUT:     rd_val[WIDTH-1:0] = out_q;
            GPIO_DIR:     rd_val[WIDTH-1:0] = dir_q;
            GPIO_IN:      rd_val[WIDTH-1:0] = level;
            GPIO_RISE_EN: rd_val[WIDTH-1:0] = rise_en_q;
            GPIO_FALL_EN: rd_val[WIDTH-1:0] = fall_en_q;
            GPIO_PENDING: rd_val[WIDTH-1:0] = pending_q;
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pending_q <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr) begin
                case (idx)
                    GPIO_OUT:     out_q     <= (out_q & ~bm) | wset;
                    GPIO_DIR:     dir_q     <= (dir_q & ~bm) | wset;
                    GPIO_SET:     out_q     <= out_q | wset;
                    GPIO_CLR:     out_q     <= out_q & ~wset;
                    GPIO_RISE_EN: rise_en_q <= (rise_en_q & ~bm) | wset;
                    GPIO_FALL_EN: fall_en_q <= (fall_en_q & ~bm) | wset;
                    default:      ;
                endcase
            end
            // New events are ORed in after the clear so a same-cycle set wins.
            pending_q <= (pending_q & ~w1c) | rise | fall;
            irq       <= |(pending_q & (rise_en_q | fall_en_q));
            ready     <= acc;
            if (acc) rdata <= wen ? '0 : rd_val;
        end
    end

    assign io_out = out_q;
    assign io_oe  = dir_q;

endmodule

// File: tb/tb_gpio_port.sv
module tb_gpio_port;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam logic [31:0] BASE8 = 32'h0002_0000;
    localparam logic [31:0] R_OUT = 32'h00, R_DIR = 32'h04, R_IN = 32'h08, R_SET = 32'h0C;
    localparam logic [31:0] R_CLR = 32'h10, R_RISE = 32'h14, R_FALL = 32'h18, R_PEND = 32'h1C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wmask = '0;
    logic        wen = 1'b0, ren = 1'b0;
    logic [31:0] rdata, rdata8;
    logic        ready, ready8, active, active8, irq, irq8;
    logic [31:0] io_in = '0, io_out, io_oe;
    logic [7:0]  io_in8 = '0, io_out8, io_oe8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpio_port #(
        .WIDTH        (32),
        .BASE_ADDR    (BASE),
        .ADDR_BITS    (5),
        .SYNC_STAGES  (2),
        .DEBOUNCE_DIV (4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wmask(wmask),
        .wen(wen), .ren(ren), .rdata(rdata), .ready(ready), .active(active),
        .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .irq(irq)
    );

    gpio_port #(
        .WIDTH        (8),
        .BASE_ADDR    (BASE8),
        .ADDR_BITS    (5),
        .SYNC_STAGES  (2),
        .DEBOUNCE_DIV (4)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wmask(wmask),
        .wen(wen), .ren(ren), .rdata(rdata8), .ready(ready8), .active(active8),
        .io_in(io_in8), .io_out(io_out8), .io_oe(io_oe8), .irq(irq8)
    );

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One bus cycle: strobes driven at negedge, sampled at posedge,
    // outputs observed #1 after that edge.
    task automatic cyc(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        wen = w; ren = r; addr = a; wdata = d; wmask = m;
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, BASE, 32'h0, 4'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, BASE + R_DIR,  32'h0,         4'h0, 1'b1, 32'h0000_0000, "rd_dir_rst"};
        tbl[1]  = '{1'b0, 1'b1, BASE + R_OUT,  32'h0,         4'h0, 1'b1, 32'h0000_0000, "rd_out_rst"};
        tbl[2]  = '{1'b0, 1'b1, BASE + R_PEND, 32'h0,         4'h0, 1'b1, 32'h0000_0000, "rd_pend_rst"};
        tbl[3]  = '{1'b1, 1'b0, BASE + R_OUT,  32'hA5A5_A5A5, 4'h3, 1'b0, 32'h0,         "wr_out_lo"};
        tbl[4]  = '{1'b0, 1'b1, BASE + R_OUT,  32'h0,         4'h0, 1'b1, 32'h0000_A5A5, "rd_out_lo"};
        tbl[5]  = '{1'b1, 1'b0, BASE + R_SET,  32'h0000_0100, 4'hF, 1'b0, 32'h0,         "wr_set"};
        tbl[6]  = '{1'b1, 1'b0, BASE + R_CLR,  32'h0000_0001, 4'hF, 1'b0, 32'h0,         "wr_clr"};
        tbl[7]  = '{1'b0, 1'b1, BASE + R_OUT,  32'h0,         4'h0, 1'b1, 32'h0000_A5A4, "rd_out_setclr"};
        tbl[8]  = '{1'b0, 1'b1, BASE + R_SET,  32'h0,         4'h0, 1'b1, 32'h0000_0000, "rd_set_zero"};
        tbl[9]  = '{1'b1, 1'b0, BASE + R_DIR,  32'hFF00_FF00, 4'hF, 1'b0, 32'h0,         "wr_dir"};
        tbl[10] = '{1'b0, 1'b1, BASE + R_DIR,  32'h0,         4'h0, 1'b1, 32'hFF00_FF00, "rd_dir"};
        tbl[11] = '{1'b1, 1'b1, BASE + R_RISE, 32'h0000_0008, 4'hF, 1'b1, 32'h0000_0000, "wr_rd_both"};
        tbl[12] = '{1'b0, 1'b1, BASE + R_RISE, 32'h0,         4'h0, 1'b1, 32'h0000_0008, "rd_rise_en"};
        tbl[13] = '{1'b0, 1'b1, BASE + R_CLR,  32'h0,         4'h0, 1'b1, 32'h0000_0000, "rd_clr_zero"};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready}, 32'h0);
        check("rst_io_oe", io_oe, 32'h0);
        check("rst_io_out", io_out, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();

        // Table-driven register accesses
        for (int unsigned i = 0; i < 14; i++) begin
            cyc(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].m);
            check({tbl[i].name, "_ready"}, {31'b0, ready}, 32'h1);
            if (tbl[i].chk) check(tbl[i].name, rdata, tbl[i].exp);
            idle();
            check({tbl[i].name, "_ready_drop"}, {31'b0, ready}, 32'h0);
        end
        check("io_oe_dir", io_oe, 32'hFF00_FF00);
        check("io_out_reg", io_out, 32'h0000_A5A4);

        // Back-to-back strobes: ready follows each
        cyc(1'b0, 1'b1, BASE + R_OUT, 32'h0, 4'h0);
        check("b2b_ready0", {31'b0, ready}, 32'h1);
        cyc(1'b0, 1'b1, BASE + R_DIR, 32'h0, 4'h0);
        check("b2b_ready1", {31'b0, ready}, 32'h1);
        check("b2b_rdata1", rdata, 32'hFF00_FF00);

`ifndef GPIO_DEBOUNCE_EN
        // Rising edge on pin 3: PENDING set at edge 3, irq at edge 4
        @(negedge clk);
        io_in[3] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, BASE + R_PEND, 32'h0, 4'h0);
        check("edge_pend_early", rdata, 32'h0);
        check("edge_irq_early", {31'b0, irq}, 32'h0);
        cyc(1'b0, 1'b1, BASE + R_PEND, 32'h0, 4'h0);
        check("edge_pend_set", rdata, 32'h8);
        check("edge_irq_set", {31'b0, irq}, 32'h1);
        cyc(1'b1, 1'b0, BASE + R_PEND, 32'h8, 4'hF);
        idle();
        check("w1c_irq_clear", {31'b0, irq}, 32'h0);
        cyc(1'b0, 1'b1, BASE + R_PEND, 32'h0, 4'h0);
        check("w1c_pend_clear", rdata, 32'h0);

        // Falling edge pends bit 3, then rise collides with its W1C
        cyc(1'b1, 1'b0, BASE + R_FALL, 32'h8, 4'hF);
        @(negedge clk);
        io_in[3] = 1'b0;
        repeat (6) idle();
        cyc(1'b0, 1'b1, BASE + R_PEND, 32'h0, 4'h0);
        check("fall_pend", rdata, 32'h8);
        @(negedge clk);
        io_in[3] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, BASE + R_PEND, 32'h8, 4'hF);
        cyc(1'b0, 1'b1, BASE + R_PEND, 32'h0, 4'h0);
        check("collide_set_wins", rdata, 32'h8);

        // Clearing enables masks irq but keeps PENDING
        cyc(1'b1, 1'b0, BASE + R_RISE, 32'h0, 4'hF);
        cyc(1'b1, 1'b0, BASE + R_FALL, 32'h0, 4'hF);
        idle();
        idle();
        check("mask_irq", {31'b0, irq}, 32'h0);
        cyc(1'b0, 1'b1, BASE + R_PEND, 32'h0, 4'h0);
        check("mask_pend_kept", rdata, 32'h8);
        cyc(1'b0, 1'b1, BASE + R_IN, 32'h0, 4'h0);
        check("rd_in", rdata, 32'h8);
`else
        // Debounce: a 5-cycle glitch is rejected, a held level passes
        @(negedge clk);
        io_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        io_in[0] = 1'b0;
        repeat (20) idle();
        cyc(1'b0, 1'b1, BASE + R_IN, 32'h0, 4'h0);
        check("deb_glitch", rdata & 32'h1, 32'h0);
        @(negedge clk);
        io_in[0] = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, BASE + R_IN, 32'h0, 4'h0);
        check("deb_held", rdata & 32'h1, 32'h1);
`endif

        // WIDTH=8 instance: upper bits read 0, main instance unaffected
        cyc(1'b1, 1'b0, BASE8 + R_OUT, 32'hFFFF_FFFF, 4'hF);
        check("w8_ready", {31'b0, ready8}, 32'h1);
        check("w8_other_ready", {31'b0, ready}, 32'h0);
        cyc(1'b0, 1'b1, BASE8 + R_OUT, 32'h0, 4'h0);
        check("w8_rd_out", rdata8, 32'h0000_00FF);
        check("w8_io_out", {24'b0, io_out8}, 32'h0000_00FF);

        // Out-of-window strobe: no decode, no ready, no write
        @(negedge clk);
        wen = 1'b1; addr = 32'h0003_0000; wdata = 32'h1234_5678; wmask = 4'hF;
        #1;
        check("oow_active", {31'b0, active}, 32'h0);
        check("oow_active8", {31'b0, active8}, 32'h0);
        @(posedge clk);
        #1;
        wen = 1'b0;
        check("oow_ready", {31'b0, ready}, 32'h0);
        check("oow_ready8", {31'b0, ready8}, 32'h0);
        check("oow_io_out", io_out, 32'h0000_A5A4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
